pulpino_usb_endpoint: RTL and testbench

- Pulpino-side endpoint of the USB↔Pulpino byte channel.
- Presents word-level valid/ready ports to the Pulpino peripheral logic.
- Fetches 32-bit words from the channel as 4 bytes, and pushes 32-bit words into it as 4 bytes.
- Drives `pulpino_read_flicker` / `pulpino_write_flicker` toggle handshakes against the channel's `usb_write_flicker` / `usb_read_flicker`.
- Same clock domain as the channel; no synchronizers.

---
 rtl/pulpino_usb_endpoint.sv | 194 +++++++++++++++++++
 tb/tb_pulpino_usb_endpoint.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulpino_usb_endpoint.sv
// Pulpino-side endpoint of the USB<->Pulpino byte channel: word-level rx/tx handshakes over flicker-toggle byte transfers.
// Optional per-byte wait timeout enabled by defining PULPINO_USB_EP_TIMEOUT_EN.
module pulpino_usb_endpoint
`ifdef PULPINO_USB_EP_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic [7:0]  usb_to_pulpino_data,
    input  logic        usb_write_flicker,
    output logic        pulpino_read_flicker,
    output logic [7:0]  pulpino_to_usb_data,
    input  logic        usb_read_flicker,
    output logic        pulpino_write_flicker,
    input  logic        rx_req_i,
    output logic [31:0] rx_word_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    input  logic [31:0] tx_word_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        err_o
);

    typedef enum logic [1:0] {RX_IDLE, RX_BUSY, RX_HOLD} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_BUSY, TX_DRAIN} tx_state_e;

    rx_state_e   rx_state_q, rx_state_d;
    logic [1:0]  rx_idx_q, rx_idx_d;
    logic [31:0] rx_word_q, rx_word_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rd_flk_q, rd_flk_d;

    tx_state_e   tx_state_q, tx_state_d;
    logic [1:0]  tx_idx_q, tx_idx_d;
    logic [31:0] tx_word_q, tx_word_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        wr_flk_q, wr_flk_d;
    logic        tx_ready_q, tx_ready_d;

    logic rx_avail, rx_take, rx_abort;
    logic tx_free, tx_accept, tx_send, tx_abort;

    assign rx_avail  = (usb_write_flicker != rd_flk_q);
    assign rx_take   = (rx_state_q == RX_BUSY) && rx_avail;
    assign tx_free   = (wr_flk_q == usb_read_flicker);
    assign tx_accept = tx_ready_q && tx_valid_i;
    assign tx_send   = (tx_state_q == TX_BUSY) && tx_free;

    // ---------------- RX FSM ----------------
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rx_state_q <= RX_IDLE;
            rx_idx_q   <= 2'd0;
            rx_word_q  <= 32'd0;
            rx_valid_q <= 1'b0;
            rd_flk_q   <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_idx_q   <= rx_idx_d;
            rx_word_q  <= rx_word_d;
            rx_valid_q <= rx_valid_d;
            rd_flk_q   <= rd_flk_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE: if (rx_req_i) rx_state_d = RX_BUSY;
            RX_BUSY: begin
                if (rx_abort)                     rx_state_d = RX_IDLE;
                else if (rx_take && rx_idx_q == 2'd3) rx_state_d = RX_HOLD;
            end
            RX_HOLD: if (rx_ready_i) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_word_d  = rx_word_q;
        rx_idx_d   = rx_idx_q;
        rx_valid_d = rx_valid_q;
        rd_flk_d   = rd_flk_q;
        if (rx_state_q == RX_IDLE && rx_req_i) begin
            rx_idx_d = 2'd0;
        end
        if (rx_take) begin
            rx_word_d[{rx_idx_q, 3'b000} +: 8] = usb_to_pulpino_data;
            rd_flk_d = ~rd_flk_q;
            rx_idx_d = rx_idx_q + 2'd1;
            if (rx_idx_q == 2'd3) rx_valid_d = 1'b1;
        end
        if (rx_abort) begin
            rx_word_d = 32'd0;
        end
        if (rx_state_q == RX_HOLD && rx_ready_i) begin
            rx_valid_d = 1'b0;
        end
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            tx_state_q <= TX_IDLE;
            tx_idx_q   <= 2'd0;
            tx_word_q  <= 32'd0;
            tx_data_q  <= 8'd0;
            wr_flk_q   <= 1'b0;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_idx_q   <= tx_idx_d;
            tx_word_q  <= tx_word_d;
            tx_data_q  <= tx_data_d;
            wr_flk_q   <= wr_flk_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (tx_valid_i) tx_state_d = TX_BUSY;
            TX_BUSY: begin
                if (tx_abort)                         tx_state_d = TX_IDLE;
                else if (tx_send && tx_idx_q == 2'd3) tx_state_d = TX_DRAIN;
            end
            TX_DRAIN: if (tx_abort || tx_free) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Outgoing byte only moves on the toggle edge, so it is stable while flickers differ.
    always_comb begin
        tx_word_d  = tx_word_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        wr_flk_d   = wr_flk_q;
        tx_ready_d = (tx_state_d == TX_IDLE);
        if (tx_accept) begin
            tx_word_d = tx_word_i;
            tx_idx_d  = 2'd0;
        end
        if (tx_send) begin
            tx_data_d = tx_word_q[{tx_idx_q, 3'b000} +: 8];
            wr_flk_d  = ~wr_flk_q;
            tx_idx_d  = tx_idx_q + 2'd1;
        end
    end

`ifdef PULPINO_USB_EP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] rx_cnt_q, tx_cnt_q;
    logic             err_q;
    logic             rx_wait, tx_wait;

    // Counters hold zero whenever the FSM is not stalled, which covers entry and byte progress.
    assign rx_wait  = (rx_state_q == RX_BUSY) && !rx_avail;
    assign tx_wait  = ((tx_state_q == TX_BUSY) || (tx_state_q == TX_DRAIN)) && !tx_free;
    assign rx_abort = rx_wait && (rx_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tx_abort = tx_wait && (tx_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rx_cnt_q <= (rx_wait && !rx_abort) ? rx_cnt_q + 1'b1 : '0;
            tx_cnt_q <= (tx_wait && !tx_abort) ? tx_cnt_q + 1'b1 : '0;
            err_q    <= err_q | rx_abort | tx_abort;
        end
    end

    assign err_o = err_q;
`else
    assign rx_abort = 1'b0;
    assign tx_abort = 1'b0;
    assign err_o    = 1'b0;
`endif

    assign pulpino_read_flicker  = rd_flk_q;
    assign pulpino_write_flicker = wr_flk_q;
    assign pulpino_to_usb_data   = tx_data_q;
    assign rx_word_o             = rx_word_q;
    assign rx_valid_o            = rx_valid_q;
    assign tx_ready_o            = tx_ready_q;

endmodule

// File: tb/tb_pulpino_usb_endpoint.sv
// Testbench for pulpino_usb_endpoint with a behavioural model of the USB<->Pulpino byte channel.
module tb_pulpino_usb_endpoint;

    logic        clk;
    logic        reset_i;
    logic [7:0]  usb_to_pulpino_data;
    logic        usb_write_flicker;
    logic        pulpino_read_flicker;
    logic [7:0]  pulpino_to_usb_data;
    logic        usb_read_flicker;
    logic        pulpino_write_flicker;
    logic        rx_req_i;
    logic [31:0] rx_word_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic [31:0] tx_word_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic        err_o;

    int n_checks = 0;
    int n_err    = 0;

`ifdef PULPINO_USB_EP_TIMEOUT_EN
    pulpino_usb_endpoint #(.TIMEOUT_CYCLES(16)) dut (
`else
    pulpino_usb_endpoint dut (
`endif
        .clk                   (clk),
        .reset_i               (reset_i),
        .usb_to_pulpino_data   (usb_to_pulpino_data),
        .usb_write_flicker     (usb_write_flicker),
        .pulpino_read_flicker  (pulpino_read_flicker),
        .pulpino_to_usb_data   (pulpino_to_usb_data),
        .usb_read_flicker      (usb_read_flicker),
        .pulpino_write_flicker (pulpino_write_flicker),
        .rx_req_i              (rx_req_i),
        .rx_word_o             (rx_word_o),
        .rx_valid_o            (rx_valid_o),
        .rx_ready_i            (rx_ready_i),
        .tx_word_i             (tx_word_i),
        .tx_valid_i            (tx_valid_i),
        .tx_ready_o            (tx_ready_o),
        .err_o                 (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel model: offers ch_src words byte by byte, collects sent bytes into ch_tx_reg.
    logic [31:0] ch_src [4];
    logic [1:0]  ch_wcnt;
    logic [1:0]  ch_rx_idx;
    logic [31:0] ch_tx_reg;
    logic [1:0]  ch_tx_idx;
    logic        ch_freeze;

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            usb_to_pulpino_data <= 8'h00;
            usb_write_flicker   <= 1'b0;
            ch_rx_idx           <= 2'd0;
            ch_wcnt             <= 2'd0;
            ch_tx_reg           <= 32'h0;
            ch_tx_idx           <= 2'd0;
            usb_read_flicker    <= 1'b0;
        end else if (!ch_freeze) begin
            if (usb_write_flicker == pulpino_read_flicker) begin
                usb_to_pulpino_data <= ch_src[ch_wcnt][{ch_rx_idx, 3'b000} +: 8];
                usb_write_flicker   <= ~usb_write_flicker;
                ch_rx_idx           <= ch_rx_idx + 2'd1;
                if (ch_rx_idx == 2'd3) ch_wcnt <= ch_wcnt + 2'd1;
            end
            if (pulpino_write_flicker != usb_read_flicker) begin
                ch_tx_reg[{ch_tx_idx, 3'b000} +: 8] <= pulpino_to_usb_data;
                usb_read_flicker <= ~usb_read_flicker;
                ch_tx_idx        <= ch_tx_idx + 2'd1;
            end
        end
    end

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i    = 1'b1;
        rx_req_i   = 1'b0;
        rx_ready_i = 1'b0;
        tx_valid_i = 1'b0;
        tx_word_i  = 32'h0;
        step();
        step();
        reset_i = 1'b0;
        step();
        step();
    endtask

    task automatic wait_rx_valid(input string nm);
        int n = 0;
        while (rx_valid_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check1(nm, rx_valid_o, 1'b1);
    endtask

    task automatic wait_tx_ready(input string nm);
        int n = 0;
        while (tx_ready_o !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check1(nm, tx_ready_o, 1'b1);
    endtask

    typedef struct {
        logic [31:0] rx_src;
        logic [31:0] tx_word;
        logic [31:0] exp_rx;
        logic [31:0] exp_tx;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{rx_src: 32'hDEADBEEF, tx_word: 32'h12345678, exp_rx: 32'hDEADBEEF, exp_tx: 32'h12345678};
        vecs[1] = '{rx_src: 32'h00000000, tx_word: 32'hFFFFFFFF, exp_rx: 32'h00000000, exp_tx: 32'hFFFFFFFF};
        vecs[2] = '{rx_src: 32'hA55A0FF0, tx_word: 32'h01020304, exp_rx: 32'hA55A0FF0, exp_tx: 32'h01020304};
        vecs[3] = '{rx_src: 32'hFFFFFFFF, tx_word: 32'h80000001, exp_rx: 32'hFFFFFFFF, exp_tx: 32'h80000001};

        ch_freeze = 1'b0;
        for (int i = 0; i < 4; i++) ch_src[i] = 32'h0;
        do_reset();

        check1 ("rst_rd_flk",   pulpino_read_flicker, 1'b0);
        check1 ("rst_wr_flk",   pulpino_write_flicker, 1'b0);
        check32("rst_tx_data",  {24'h0, pulpino_to_usb_data}, 32'h0);
        check32("rst_rx_word",  rx_word_o, 32'h0);
        check1 ("rst_rx_valid", rx_valid_o, 1'b0);
        check1 ("rst_tx_ready", tx_ready_o, 1'b1);
        check1 ("rst_err",      err_o, 1'b0);

        // Concurrent single-word transfers with exact edge timing.
        for (int v = 0; v < 4; v++) begin
            ch_src[0] = vecs[v].rx_src;
            do_reset();
            rx_req_i   = 1'b1;
            tx_valid_i = 1'b1;
            tx_word_i  = vecs[v].tx_word;
            step();
            rx_req_i   = 1'b0;
            tx_valid_i = 1'b0;
            tx_word_i  = 32'h0;
            check1("tx_ready_after_accept", tx_ready_o, 1'b0);
            for (int e = 1; e <= 9; e++) begin
                logic [31:0] sh;
                step();
                sh = vecs[v].exp_tx >> (4 * (e - 1));
                if (e % 2 == 1 && e <= 7)
                    check32("tx_byte_order", {24'h0, pulpino_to_usb_data}, {24'h0, sh[7:0]});
                if (e == 6) check1("rx_valid_early", rx_valid_o, 1'b0);
                if (e == 7) begin
                    check1 ("rx_valid_edge7", rx_valid_o, 1'b1);
                    check32("rx_word", rx_word_o, vecs[v].exp_rx);
                end
                if (e == 8) begin
                    check32("chan_tx_reg_edge8", ch_tx_reg, vecs[v].exp_tx);
                    check1 ("tx_ready_edge8", tx_ready_o, 1'b0);
                end
                if (e == 9) check1("tx_ready_edge9", tx_ready_o, 1'b1);
            end
            rx_ready_i = 1'b1;
            step();
            check1("rx_valid_cleared", rx_valid_o, 1'b0);
            rx_ready_i = 1'b0;
        end

        // Hold with ready low, then back-to-back words in both directions.
        ch_src[0] = 32'hDEADBEEF;
        ch_src[1] = 32'hCAFEF00D;
        do_reset();
        rx_req_i   = 1'b1;
        tx_valid_i = 1'b1;
        tx_word_i  = 32'hAABBCCDD;
        step();
        rx_req_i   = 1'b0;
        tx_valid_i = 1'b0;
        fork
            begin
                wait_rx_valid("rx_w1_valid");
                for (int k = 0; k < 5; k++) step();
                check1 ("rx_hold_valid", rx_valid_o, 1'b1);
                check32("rx_hold_word", rx_word_o, 32'hDEADBEEF);
                check1 ("rx_hold_no_toggle", pulpino_read_flicker, 1'b0);
                rx_ready_i = 1'b1;
                rx_req_i   = 1'b1;
                step();
                check1("rx_hold_release", rx_valid_o, 1'b0);
                step();
                rx_req_i = 1'b0;
                wait_rx_valid("rx_w2_valid");
                check32("rx_w2_word", rx_word_o, 32'hCAFEF00D);
                rx_ready_i = 1'b0;
            end
            begin
                wait_tx_ready("tx_w1_ready");
                check32("tx_w1_chan", ch_tx_reg, 32'hAABBCCDD);
                tx_valid_i = 1'b1;
                tx_word_i  = 32'h11223344;
                step();
                tx_valid_i = 1'b0;
                tx_word_i  = 32'h0;
                check1("tx_w2_busy", tx_ready_o, 1'b0);
                wait_tx_ready("tx_w2_ready");
                check32("tx_w2_chan", ch_tx_reg, 32'h11223344);
            end
        join

        // Asynchronous reset in the middle of both transfers.
        ch_src[0] = 32'hDEADBEEF;
        do_reset();
        rx_req_i   = 1'b1;
        tx_valid_i = 1'b1;
        tx_word_i  = 32'h12345678;
        step();
        rx_req_i   = 1'b0;
        tx_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) step();
        reset_i = 1'b1;
        #1;
        check1 ("midrst_rd_flk",   pulpino_read_flicker, 1'b0);
        check1 ("midrst_wr_flk",   pulpino_write_flicker, 1'b0);
        check32("midrst_tx_data",  {24'h0, pulpino_to_usb_data}, 32'h0);
        check32("midrst_rx_word",  rx_word_o, 32'h0);
        check1 ("midrst_rx_valid", rx_valid_o, 1'b0);
        check1 ("midrst_tx_ready", tx_ready_o, 1'b1);
        check1 ("midrst_err",      err_o, 1'b0);
        do_reset();

        // Frozen channel: transfers stall after the first TX byte.
        ch_freeze = 1'b1;
        do_reset();
        rx_req_i   = 1'b1;
        tx_valid_i = 1'b1;
        tx_word_i  = 32'h12345678;
        step();
        rx_req_i   = 1'b0;
        tx_valid_i = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check1("stall_err_early", err_o, 1'b0);
        check1("stall_tx_busy_early", tx_ready_o, 1'b0);
        for (int k = 0; k < 30; k++) step();
        check1("stall_rx_valid", rx_valid_o, 1'b0);
        check1("stall_wr_flk", pulpino_write_flicker, 1'b1);
`ifdef PULPINO_USB_EP_TIMEOUT_EN
        check1("timeout_err", err_o, 1'b1);
        check1("timeout_tx_ready", tx_ready_o, 1'b1);
`else
        check1("no_timeout_err", err_o, 1'b0);
        check1("no_timeout_tx_busy", tx_ready_o, 1'b0);
`endif
        ch_freeze = 1'b0;
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
